fib_seq_checker: RTL and testbench

- Stream-side checker for the Fibonacci generator output.
- Consumes a valid/ready data stream and verifies that it follows F0=1, F1=1, Fn=Fn-1+Fn-2.
- Reports the matched-term count, a sticky error with the failing index, and a done flag when the next term would no longer fit in DATA_WIDTH.
- Used as an in-design self-check/monitor on generator links.

---
 rtl/fib_seq_checker_if.sv | 15 +
 rtl/fib_seq_checker.sv | 106 ++++++++++
 tb/tb_fib_seq_checker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fib_seq_checker_if.sv
// Valid/ready term stream feeding fib_seq_checker.
//   in_valid : producer has a term on in_data
//   in_data  : term under check
//   in_ready : checker accepts the term this cycle
// master = producer side, slave = checker side.
interface fib_seq_checker_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fib_seq_checker.sv
// Stream-side Fibonacci checker: verifies that accepted terms follow
// F0=1, F1=1, Fn=Fn-1+Fn-2.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   clear     : synchronous re-arm, restarts checking from F0
//   in_if     : valid/ready term stream (slave side)
//   expected  : value the next accepted term must equal
//   match_cnt : consecutive matched terms since reset/clear (saturating)
//   err       : sticky mismatch flag
//   err_pulse : one-cycle strobe after a mismatch
//   err_index : 0-based index of the first mismatching term
//   done      : next term would overflow DATA_WIDTH
module fib_seq_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  fib_seq_checker_if.slave      in_if,
  output logic [DATA_WIDTH-1:0] expected,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic                  err,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_index,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FAIL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] prev, cur, prev_n, cur_n;
  logic [CNT_WIDTH-1:0]  cnt_n, idx_n;
  logic                  err_n, pulse_n, done_n;
  logic [DATA_WIDTH:0]   sum;
  logic                  accept;

  assign in_if.in_ready = (state == ST_RUN) & ~clear;
  assign accept         = in_if.in_valid & in_if.in_ready;
  assign expected       = cur;
  // One extra bit so the carry out flags the end of the representable sequence.
  assign sum            = {1'b0, prev} + {1'b0, cur};

  always_comb begin
    state_n = state;
    prev_n  = prev;
    cur_n   = cur;
    cnt_n   = match_cnt;
    err_n   = err;
    pulse_n = 1'b0;
    idx_n   = err_index;
    done_n  = done;
    case (state)
      ST_RUN: begin
        if (accept) begin
          if (in_if.in_data == cur) begin
            cnt_n = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;
            if (sum[DATA_WIDTH]) begin
              // prev/cur stay put so expected keeps showing the last good term.
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else begin
              prev_n = cur;
              cur_n  = sum[DATA_WIDTH-1:0];
            end
          end else begin
            state_n = ST_FAIL;
            err_n   = 1'b1;
            pulse_n = 1'b1;
            idx_n   = match_cnt;
          end
        end
      end
      ST_FAIL: ;
      ST_DONE: ;
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= ST_RUN;
      prev      <= '0;
      cur       <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      match_cnt <= '0;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      err_index <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      cur       <= cur_n;
      match_cnt <= cnt_n;
      err       <= err_n;
      err_pulse <= pulse_n;
      err_index <= idx_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_fib_seq_checker.sv
module tb_fib_seq_checker;

  logic clk = 1'b0;
  logic reset, clear;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // 32-bit instance
  fib_seq_checker_if #(.DATA_WIDTH(32)) if32 ();
  logic [31:0] exp32;
  logic [15:0] cnt32, idx32;
  logic        err32, pls32, done32;

  fib_seq_checker #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut32 (
    .clk(clk), .reset(reset), .clear(clear), .in_if(if32.slave),
    .expected(exp32), .match_cnt(cnt32), .err(err32), .err_pulse(pls32),
    .err_index(idx32), .done(done32)
  );

  // 8-bit instance
  fib_seq_checker_if #(.DATA_WIDTH(8)) if8 ();
  logic [7:0]  exp8;
  logic [15:0] cnt8, idx8;
  logic        err8, pls8, done8;

  fib_seq_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .in_if(if8.slave),
    .expected(exp8), .match_cnt(cnt8), .err(err8), .err_pulse(pls8),
    .err_index(idx8), .done(done8)
  );

  // 8-bit data with a 3-bit counter, to see the count saturate
  fib_seq_checker_if #(.DATA_WIDTH(8)) if8s ();
  logic [7:0] exp8s;
  logic [2:0] cnt8s, idx8s;
  logic       err8s, pls8s, done8s;

  fib_seq_checker #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut8s (
    .clk(clk), .reset(reset), .clear(clear), .in_if(if8s.slave),
    .expected(exp8s), .match_cnt(cnt8s), .err(err8s), .err_pulse(pls8s),
    .err_index(idx8s), .done(done8s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  typedef struct {
    logic        rst, clr, v;
    logic [31:0] d;
    logic        rdy;
    logic [31:0] ex;
    logic [15:0] cnt;
    logic        err, pulse;
    logic [15:0] idx;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  function automatic void r(input logic rst, input logic clr, input logic v,
                            input logic [31:0] d, input logic rdy, input logic [31:0] ex,
                            input logic [15:0] cnt, input logic e, input logic p,
                            input logic [15:0] idx, input logic dn);
    vec_t t;
    t.rst = rst; t.clr = clr; t.v = v; t.d = d; t.rdy = rdy; t.ex = ex;
    t.cnt = cnt; t.err = e; t.pulse = p; t.idx = idx; t.done = dn;
    tbl.push_back(t);
  endfunction

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a, b, t;

    reset = 1'b1; clear = 1'b0;
    if32.in_valid = 1'b0; if32.in_data = '0;
    if8.in_valid  = 1'b0; if8.in_data  = '0;
    if8s.in_valid = 1'b0; if8s.in_data = '0;
    tick(); tick();
    chk("reset_expected", exp32, 1);
    chk("reset_cnt", cnt32, 0);
    chk("reset_err", err32, 0);
    chk("reset_pulse", pls32, 0);
    chk("reset_done", done32, 0);
    reset = 1'b0;

    //  rst clr v  d     rdy ex  cnt err pls idx done
    // back-to-back 1,1,2,3,5,8,13
    r(0, 0, 1, 1,    1, 1,  1, 0, 0, 0, 0);
    r(0, 0, 1, 1,    1, 2,  2, 0, 0, 0, 0);
    r(0, 0, 1, 2,    1, 3,  3, 0, 0, 0, 0);
    r(0, 0, 1, 3,    1, 5,  4, 0, 0, 0, 0);
    r(0, 0, 1, 5,    1, 8,  5, 0, 0, 0, 0);
    r(0, 0, 1, 8,    1, 13, 6, 0, 0, 0, 0);
    r(0, 0, 1, 13,   1, 21, 7, 0, 0, 0, 0);
    r(0, 1, 0, JUNK, 0, 1,  0, 0, 0, 0, 0);
    // same sequence with idle gaps; data is junk while invalid
    r(0, 0, 0, JUNK, 1, 1,  0, 0, 0, 0, 0);
    r(0, 0, 1, 1,    1, 1,  1, 0, 0, 0, 0);
    r(0, 0, 0, JUNK, 1, 1,  1, 0, 0, 0, 0);
    r(0, 0, 0, 1,    1, 1,  1, 0, 0, 0, 0);
    r(0, 0, 1, 1,    1, 2,  2, 0, 0, 0, 0);
    r(0, 0, 1, 2,    1, 3,  3, 0, 0, 0, 0);
    r(0, 0, 0, JUNK, 1, 3,  3, 0, 0, 0, 0);
    r(0, 0, 0, 7,    1, 3,  3, 0, 0, 0, 0);
    r(0, 0, 0, JUNK, 1, 3,  3, 0, 0, 0, 0);
    r(0, 0, 1, 3,    1, 5,  4, 0, 0, 0, 0);
    r(0, 0, 1, 5,    1, 8,  5, 0, 0, 0, 0);
    r(0, 0, 0, JUNK, 1, 8,  5, 0, 0, 0, 0);
    r(0, 0, 1, 8,    1, 13, 6, 0, 0, 0, 0);
    r(0, 0, 0, JUNK, 1, 13, 6, 0, 0, 0, 0);
    r(0, 0, 0, JUNK, 1, 13, 6, 0, 0, 0, 0);
    r(0, 0, 1, 13,   1, 21, 7, 0, 0, 0, 0);
    r(0, 1, 0, JUNK, 0, 1,  0, 0, 0, 0, 0);
    // mismatch 1,1,2,4 then a further beat is ignored
    r(0, 0, 1, 1,    1, 1,  1, 0, 0, 0, 0);
    r(0, 0, 1, 1,    1, 2,  2, 0, 0, 0, 0);
    r(0, 0, 1, 2,    1, 3,  3, 0, 0, 0, 0);
    r(0, 0, 1, 4,    1, 3,  3, 1, 1, 3, 0);
    r(0, 0, 1, 3,    0, 3,  3, 1, 0, 3, 0);
    r(0, 0, 0, JUNK, 0, 3,  3, 1, 0, 3, 0);
    // clear from FAIL with a beat offered in the same cycle
    r(0, 1, 1, 1,    0, 1,  0, 0, 0, 0, 0);
    r(0, 0, 1, 1,    1, 1,  1, 0, 0, 0, 0);
    r(0, 0, 1, 1,    1, 2,  2, 0, 0, 0, 0);
    // reset mid-sequence after 1,1,2,3
    r(0, 0, 1, 2,    1, 3,  3, 0, 0, 0, 0);
    r(0, 0, 1, 3,    1, 5,  4, 0, 0, 0, 0);
    r(1, 0, 1, 5,    1, 1,  0, 0, 0, 0, 0);
    r(0, 0, 1, 1,    1, 1,  1, 0, 0, 0, 0);
    r(0, 0, 1, 1,    1, 2,  2, 0, 0, 0, 0);
    // mismatch at index 2, then reset out of FAIL
    r(0, 0, 1, 5,    1, 2,  2, 1, 1, 2, 0);
    r(1, 0, 0, JUNK, 0, 1,  0, 0, 0, 0, 0);
    r(0, 0, 0, JUNK, 1, 1,  0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; clear = tbl[i].clr;
      if32.in_valid = tbl[i].v; if32.in_data = tbl[i].d;
      #1;
      chk($sformatf("v%0d_in_ready", i), if32.in_ready, tbl[i].rdy);
      tick();
      chk($sformatf("v%0d_expected", i), exp32, tbl[i].ex);
      chk($sformatf("v%0d_match_cnt", i), cnt32, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), err32, tbl[i].err);
      chk($sformatf("v%0d_err_pulse", i), pls32, tbl[i].pulse);
      chk($sformatf("v%0d_err_index", i), idx32, tbl[i].idx);
      chk($sformatf("v%0d_done", i), done32, tbl[i].done);
    end
    reset = 1'b0; clear = 1'b0; if32.in_valid = 1'b0;

    // 32-bit exhaustion: 47 terms, last is 2971215073
    clear = 1'b1; tick(); clear = 1'b0;
    a = 1; b = 1;
    for (int i = 0; i < 47; i++) begin
      if32.in_valid = 1'b1; if32.in_data = a[31:0];
      tick();
      t = a + b; a = b; b = t;
    end
    if32.in_valid = 1'b0;
    #1;
    chk("w32_done", done32, 1);
    chk("w32_match_cnt", cnt32, 47);
    chk("w32_expected", exp32, 64'd2971215073);
    chk("w32_in_ready", if32.in_ready, 0);
    chk("w32_err", err32, 0);

    // 8-bit exhaustion on both 8-bit instances
    clear = 1'b1; tick(); clear = 1'b0;
    a = 1; b = 1;
    for (int i = 0; i < 13; i++) begin
      if8.in_valid = 1'b1;  if8.in_data  = a[7:0];
      if8s.in_valid = 1'b1; if8s.in_data = a[7:0];
      tick();
      if (i == 11) begin
        chk("w8_done_early", done8, 0);
        chk("w8_expected_233", exp8, 233);
      end
      t = a + b; a = b; b = t;
    end
    #1;
    chk("w8_done", done8, 1);
    chk("w8_match_cnt", cnt8, 13);
    chk("w8_expected", exp8, 233);
    chk("w8_in_ready", if8.in_ready, 0);
    chk("w8_err", err8, 0);
    chk("w8s_match_cnt_sat", cnt8s, 7);
    chk("w8s_done", done8s, 1);
    // DONE ignores further beats, including wrong ones
    if8.in_data = 8'd121;
    tick();
    chk("w8_after_done_err", err8, 0);
    chk("w8_after_done_cnt", cnt8, 13);
    chk("w8_after_done_pulse", pls8, 0);
    if8.in_valid = 1'b0; if8s.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
